// File: rtl/bce_predict_unit_if.sv
// Branch resolve / predict bus for bce_predict_unit.
// master = pipeline side (drives decode PC and EX branch), slave = the unit.
interface bce_predict_unit_if #(
  parameter int WIDTH     = 32,
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
);
  // decode-stage prediction lookup
  logic [PC_WIDTH-1:0]  pred_pc;
  logic                 pred_taken;
  // EX-stage resolution request
  logic                 res_valid;
  logic [PC_WIDTH-1:0]  res_pc;
  logic                 res_pred;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [3:0]           bf;
  logic                 flush;
  // registered verdict
  logic                 out_valid;
  logic                 bcres;
  logic                 mispredict;
  logic                 illegal_bf;
  logic [CNT_WIDTH-1:0] mispredict_count;

  modport master (
    output pred_pc, res_valid, res_pc, res_pred, a, b, bf, flush,
    input  pred_taken, out_valid, bcres, mispredict, illegal_bf, mispredict_count
  );

  modport slave (
    input  pred_pc, res_valid, res_pc, res_pred, a, b, bf, flush,
    output pred_taken, out_valid, bcres, mispredict, illegal_bf, mispredict_count
  );
endinterface

// File: rtl/bce_predict_unit.sv
// Branch condition evaluator with a 2-bit saturating BHT.
// Verdict is registered one cycle after EX; prediction is a pure table read.

// One BHT entry: 2-bit saturating counter, resets to weak-not-taken.
module bce_bht_cell (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_upd,
  input  logic       i_taken,
  output logic [1:0] o_ctr
);
  logic [1:0] r_ctr;

  // saturating up on taken, down on not-taken, only when selected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_ctr <= 2'b01;
    else if (i_upd) begin
      if (i_taken && r_ctr != 2'b11)       r_ctr <= r_ctr + 2'd1;
      else if (!i_taken && r_ctr != 2'b00) r_ctr <= r_ctr - 2'd1;
    end
  end

  assign o_ctr = r_ctr;
endmodule

module bce_predict_unit #(
  parameter int WIDTH       = 32,
  parameter int PC_WIDTH    = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bce_predict_unit_if.slave     bus
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic                          w_cond;
  logic                          w_illegal;
  logic                          w_a_neg;
  logic                          w_a_zero;
  logic                          w_acc;
  logic                          w_bht_we;
  logic                          w_mis;
  logic [IDX_W-1:0]              w_res_idx;
  logic [IDX_W-1:0]              w_pred_idx;
  logic [BHT_ENTRIES-1:0]        w_upd;
  logic [BHT_ENTRIES-1:0][1:0]   w_ctr;
  logic                          w_unused;

  logic                          r_out_valid;
  logic                          r_bcres;
  logic                          r_mispredict;
  logic                          r_illegal;
  logic [CNT_WIDTH-1:0]          r_cnt;

  // word-aligned PC bits select the entry; low and high PC bits are don't-care
  assign w_res_idx  = bus.res_pc[IDX_W+1:2];
  assign w_pred_idx = bus.pred_pc[IDX_W+1:2];
  assign w_unused   = &{1'b0, bus.res_pc, bus.pred_pc};

  assign w_a_neg  = bus.a[WIDTH-1];
  assign w_a_zero = (bus.a == '0);

  // condition decode; undefined codes resolve not-taken and flag illegal
  always_comb begin
    w_cond    = 1'b0;
    w_illegal = 1'b0;
    unique case (bus.bf)
      4'b0010: w_cond = w_a_neg;
      4'b0011: w_cond = ~w_a_neg;
      4'b0100: w_cond = ($signed(bus.a) <  $signed(bus.b));
      4'b0101: w_cond = ($signed(bus.a) >= $signed(bus.b));
      4'b0110: w_cond = (bus.a <  bus.b);
      4'b0111: w_cond = (bus.a >= bus.b);
      4'b1000: w_cond = (bus.a == bus.b);
      4'b1010: w_cond = (bus.a != bus.b);
      4'b1100: w_cond = w_a_neg | w_a_zero;
      4'b1110: w_cond = ~w_a_neg & ~w_a_zero;
      default: w_illegal = 1'b1;
    endcase
  end

  // flush wins over res_valid; illegal codes never train or count
  assign w_acc    = bus.res_valid & ~bus.flush;
  assign w_bht_we = w_acc & ~w_illegal;
  assign w_mis    = w_bht_we & (w_cond != bus.res_pred);

  // one counter cell per table entry, write-enabled by index match
  generate
    for (genvar g = 0; g < BHT_ENTRIES; g++) begin : g_bht
      assign w_upd[g] = w_bht_we && (w_res_idx == IDX_W'(g));
      bce_bht_cell u_cell (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_upd   (w_upd[g]),
        .i_taken (w_cond),
        .o_ctr   (w_ctr[g])
      );
    end
  endgenerate

  // prediction reads current state only: a same-cycle update is not bypassed
  assign bus.pred_taken = w_ctr[w_pred_idx][1];

  // registered verdict; bcres holds across idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_bcres      <= 1'b0;
      r_mispredict <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      r_out_valid  <= w_acc;
      r_mispredict <= w_mis;
      r_illegal    <= w_acc & w_illegal;
      if (w_acc) r_bcres <= w_cond;
    end
  end

  // mispredict counter, sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_cnt <= '0;
    else if (w_mis && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
  end

  assign bus.out_valid        = r_out_valid;
  assign bus.bcres            = r_bcres;
  assign bus.mispredict       = r_mispredict;
  assign bus.illegal_bf       = r_illegal;
  assign bus.mispredict_count = r_cnt;
endmodule

// File: tb/tb_bce_predict_unit.sv
// Directed bench: scoreboard on the default-parameter unit, plus a narrow
// instance (WIDTH=8, BHT_ENTRIES=2, CNT_WIDTH=4) for aliasing and saturation.
module tb_bce_predict_unit;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  bce_predict_unit_if #(.WIDTH(32), .PC_WIDTH(32), .CNT_WIDTH(16)) if0 ();
  bce_predict_unit_if #(.WIDTH(8),  .PC_WIDTH(32), .CNT_WIDTH(4))  if1 ();

  bce_predict_unit #(.WIDTH(32), .PC_WIDTH(32), .BHT_ENTRIES(64), .CNT_WIDTH(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  bce_predict_unit #(.WIDTH(8), .PC_WIDTH(32), .BHT_ENTRIES(2), .CNT_WIDTH(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  typedef struct packed { logic bcres; logic mis; logic ill; } exp_t;
  exp_t q[$];

  int checks  = 0;
  int errors  = 0;
  int exp_cnt = 0;
  int exp1    = 0;
  logic last_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // response monitor: every registered verdict must match the next expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && if0.out_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out: out_valid=1 expected no response");
      end else begin
        e = q.pop_front();
        chk("bcres",      {31'b0, if0.bcres},      {31'b0, e.bcres});
        chk("mispredict", {31'b0, if0.mispredict}, {31'b0, e.mis});
        chk("illegal_bf", {31'b0, if0.illegal_bf}, {31'b0, e.ill});
      end
    end
  end

  task automatic drive(input logic [3:0] bf, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic pred, input logic fl,
                       input logic eb, input logic em, input logic ei);
    if0.res_valid = 1'b1; if0.flush = fl; if0.bf = bf; if0.a = a; if0.b = b;
    if0.res_pc = pc; if0.res_pred = pred;
    if (!fl) begin
      q.push_back({eb, em, ei});
      exp_cnt += int'(em);
    end
    last_acc = !fl;
  endtask

  task automatic step();
    @(posedge clk); #1;
    chk("out_valid_timing", {31'b0, if0.out_valid}, {31'b0, last_acc});
    chk("count", {16'b0, if0.mispredict_count}, exp_cnt);
    if0.res_valid = 1'b0; if0.flush = 1'b0; last_acc = 1'b0;
  endtask

  task automatic issue(input logic [3:0] bf, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic pred, input logic fl,
                       input logic eb, input logic em, input logic ei);
    drive(bf, a, b, pc, pred, fl, eb, em, ei);
    step();
  endtask

  task automatic pchk(input string name, input logic [31:0] pc, input logic exp);
    if0.pred_pc = pc; #1;
    chk(name, {31'b0, if0.pred_taken}, {31'b0, exp});
  endtask

  task automatic issue1(input logic [3:0] bf, input logic [7:0] a, input logic [7:0] b,
                        input logic [31:0] pc, input logic pred);
    if1.res_valid = 1'b1; if1.flush = 1'b0; if1.bf = bf; if1.a = a; if1.b = b;
    if1.res_pc = pc; if1.res_pred = pred;
    @(posedge clk); #1;
    if1.res_valid = 1'b0;
  endtask

  task automatic pchk1(input string name, input logic [31:0] pc, input logic exp);
    if1.pred_pc = pc; #1;
    chk(name, {31'b0, if1.pred_taken}, {31'b0, exp});
  endtask

  initial begin
    if0.pred_pc = '0; if0.res_valid = 0; if0.res_pc = '0; if0.res_pred = 0;
    if0.a = '0; if0.b = '0; if0.bf = '0; if0.flush = 0;
    if1.pred_pc = '0; if1.res_valid = 0; if1.res_pc = '0; if1.res_pred = 0;
    if1.a = '0; if1.b = '0; if1.bf = '0; if1.flush = 0;

    // reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid",  {31'b0, if0.out_valid},  0);
    chk("rst_bcres",      {31'b0, if0.bcres},      0);
    chk("rst_mispredict", {31'b0, if0.mispredict}, 0);
    chk("rst_illegal",    {31'b0, if0.illegal_bf}, 0);
    chk("rst_count",      {16'b0, if0.mispredict_count}, 0);
    chk("rst_count1",     {28'b0, if1.mispredict_count}, 0);
    pchk("rst_pred", 32'h0040_0010, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // first resolution: taken, predicted not-taken -> mispredict, entry 01->10
    issue(4'b1000, 5, 5, 32'h0040_0010, 0, 0, 1, 1, 0);
    pchk("pred_after_first", 32'h0040_0010, 1'b1);

    // compare modes on a=-1, b=1 and a few boundaries, back-to-back
    issue(4'b0100, 32'hFFFF_FFFF, 1, 32'h100, 0, 0, 1, 1, 0);
    issue(4'b0110, 32'hFFFF_FFFF, 1, 32'h100, 0, 0, 0, 0, 0);
    issue(4'b1100, 32'hFFFF_FFFF, 1, 32'h100, 0, 0, 1, 1, 0);
    issue(4'b1110, 32'hFFFF_FFFF, 1, 32'h100, 0, 0, 0, 0, 0);
    issue(4'b0010, 32'hFFFF_FFFF, 1, 32'h100, 0, 0, 1, 1, 0);
    issue(4'b0011, 32'hFFFF_FFFF, 1, 32'h100, 0, 0, 0, 0, 0);
    issue(4'b0101, 32'hFFFF_FFFF, 1, 32'h100, 0, 0, 0, 0, 0);
    issue(4'b0111, 32'hFFFF_FFFF, 1, 32'h100, 0, 0, 1, 1, 0);
    issue(4'b1010, 32'hFFFF_FFFF, 1, 32'h100, 0, 0, 1, 1, 0);
    issue(4'b1000, 32'hFFFF_FFFF, 1, 32'h100, 0, 0, 0, 0, 0);
    issue(4'b1100, 0, 0, 32'h100, 1, 0, 1, 0, 0);
    issue(4'b1110, 0, 0, 32'h100, 1, 0, 0, 1, 0);
    issue(4'b0011, 0, 0, 32'h100, 1, 0, 1, 0, 0);
    issue(4'b0100, 32'h8000_0000, 32'h7FFF_FFFF, 32'h100, 1, 0, 1, 0, 0);
    issue(4'b0110, 32'h8000_0000, 32'h7FFF_FFFF, 32'h100, 1, 0, 0, 1, 0);

    // saturation: 5 taken then 2 not-taken on one entry
    for (int i = 0; i < 5; i++) issue(4'b1000, 7, 7, 32'h20, 1, 0, 1, 0, 0);
    pchk("sat_taken", 32'h20, 1'b1);
    issue(4'b1000, 1, 2, 32'h20, 1, 0, 0, 1, 0);
    pchk("sat_nt1", 32'h20, 1'b1);
    issue(4'b1000, 1, 2, 32'h20, 1, 0, 0, 1, 0);
    pchk("sat_nt2", 32'h20, 1'b0);

    // flush: no output, no training
    issue(4'b1000, 9, 9, 32'h30, 0, 1, 0, 0, 0);
    pchk("flush_no_train", 32'h30, 1'b0);
    issue(4'b1000, 9, 9, 32'h40, 1, 0, 1, 0, 0);
    issue(4'b1000, 1, 2, 32'h40, 1, 1, 0, 0, 0);
    chk("flush_bcres_hold", {31'b0, if0.bcres}, 1);
    pchk("flush_no_untrain", 32'h40, 1'b1);

    // illegal codes: not taken, no mispredict, no training
    issue(4'b1111, 3, 3, 32'h40, 1, 0, 0, 0, 1);
    issue(4'b0001, 0, 0, 32'h40, 0, 0, 0, 0, 1);
    issue(4'b1001, 3, 3, 32'h40, 0, 0, 0, 0, 1);
    pchk("illegal_no_train", 32'h40, 1'b1);

    // same-cycle lookup on the entry being trained returns the old value
    if0.pred_pc = 32'h50;
    drive(4'b1000, 4, 4, 32'h50, 0, 0, 1, 1, 0);
    #1 chk("no_bypass", {31'b0, if0.pred_taken}, 0);
    step();
    pchk("post_update", 32'h50, 1'b1);

    // reset while a verdict is showing
    issue(4'b1000, 4, 4, 32'h50, 0, 0, 1, 1, 0);
    @(negedge clk); #1;
    rst_n = 1'b0; #1;
    chk("midrst_out_valid",  {31'b0, if0.out_valid},  0);
    chk("midrst_bcres",      {31'b0, if0.bcres},      0);
    chk("midrst_mispredict", {31'b0, if0.mispredict}, 0);
    chk("midrst_count",      {16'b0, if0.mispredict_count}, 0);
    pchk("midrst_bht", 32'h50, 1'b0);
    exp_cnt = 0;
    @(posedge clk); #1 rst_n = 1'b1;

    // narrow instance: index is pc[2] only
    issue1(4'b1000, 8'h3, 8'h3, 32'h0, 1);
    chk("n_bcres", {31'b0, if1.bcres}, 1);
    pchk1("alias_8", 32'h8, 1'b1);
    pchk1("alias_4", 32'h4, 1'b0);
    pchk1("alias_3", 32'h3, 1'b1);
    pchk1("alias_C", 32'hC, 1'b0);
    issue1(4'b0100, 8'h80, 8'h01, 32'h4, 0);
    chk("n_signed", {31'b0, if1.bcres}, 1);
    issue1(4'b0110, 8'h80, 8'h01, 32'h4, 0);
    chk("n_unsigned", {31'b0, if1.bcres}, 0);
    exp1 = 1;
    chk("n_count_start", {28'b0, if1.mispredict_count}, exp1);
    for (int i = 0; i < 20; i++) begin
      issue1(4'b1000, 8'h3, 8'h3, (i % 2 == 0) ? 32'h4 : 32'h0, 0);
      exp1 = (exp1 == 15) ? 15 : exp1 + 1;
      chk("n_count_sat", {28'b0, if1.mispredict_count}, exp1);
    end
    chk("n_mis_still", {31'b0, if1.mispredict}, 1);

    repeat (3) step();
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bce_predict_unit.md
# bce_predict_unit

Parametrised successor to the branch-condition evaluator for the MIPS pipeline. It resolves branch conditions in EX for any operand width and a wider set of compare modes. It also holds a 2-bit saturating branch history table (BHT) that gives decode-stage taken predictions and flags mispredictions. Results are registered, so the fetch/flush logic sees the verdict one cycle after resolution.

## Interface
- WIDTH, 32, operand width of a/b (≥2)
- PC_WIDTH, 32, program counter width
- BHT_ENTRIES, 64, BHT depth; power of two, 2..1024; IDX_W = log2(BHT_ENTRIES), PC_WIDTH ≥ IDX_W+2
- CNT_WIDTH, 16, mispredict counter width
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- pred_pc  input  PC_WIDTH  decode-stage branch PC
- pred_taken  output  1  combinational: MSB of BHT[pred_pc[IDX_W+1:2]]
- res_valid  input  1  EX-stage branch present this cycle
- res_pc  input  PC_WIDTH  PC of resolving branch
- res_pred  input  1  prediction that was used for this branch
- a, b  input  WIDTH  operands
- bf  input  4  condition code
- flush  input  1  squash the EX branch this cycle
- out_valid  output  1  registered: a resolution completed
- bcres  output  1  registered: condition outcome (taken)
- mispredict  output  1  registered: bcres != res_pred, gated by out_valid
- illegal_bf  output  1  registered: bf was not a defined code
- mispredict_count  output  CNT_WIDTH  saturating count of mispredicts

## Operation
- Conditions are evaluated on a and b. Signed compares use two's complement on WIDTH bits.
  - 0010: a<0
  - 0011: a≥0
  - 0100: a<b signed
  - 0101: a≥b signed
  - 0110: a<b unsigned
  - 0111: a≥b unsigned
  - 1000: a==b
  - 1010: a!=b
  - 1100: a≤0
  - 1110: a>0
- Any other bf is illegal: cond=0 and illegal=1.
- Accept condition is res_valid & ~flush. On accept:
  - out_valid←1, bcres←cond, illegal_bf←illegal.
  - mispredict←(cond != res_pred) & ~illegal.
  - If legal, update BHT[res_pc[IDX_W+1:2]]: increment on cond=1 (saturate at 3), decrement on cond=0 (saturate at 0).
  - An illegal bf leaves the BHT and the counter unchanged.
- With no accept: out_valid←0, mispredict←0, illegal_bf←0, and bcres holds its value.
- mispredict_count increments on each cycle a mispredict is registered. It saturates at all-ones and does not wrap.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction is the counter MSB.
- res_pc[1:0] and the upper PC bits are ignored. Aliasing between PCs is permitted.

## Timing
- Reset (async assert, sync-safe release):
  - every BHT entry = 01
  - out_valid = 0, bcres = 0, mispredict = 0, illegal_bf = 0, mispredict_count = 0
- Latency: res_valid at cycle N → out_valid/bcres/mispredict valid at cycle N+1, exactly one cycle. The unit is fully pipelined and accepts a branch every cycle; there is no backpressure.
- The BHT update lands at the edge ending cycle N and is visible to pred_taken from cycle N+1.
- If pred_pc and res_pc map to the same index in the same cycle, pred_taken returns the pre-update value. There is no bypass.
- flush takes priority over res_valid in the same cycle: no update, no output, no count.
- Reset asserted mid-operation clears everything immediately. A branch in flight at reset is lost.
- pred_taken is purely combinational from pred_pc and BHT state, with no path from res_* inputs.

## Test plan
- Reset, then pred_pc=0x00400010 → pred_taken=0. Then res_valid with bf=1000, a=b=5, res_pred=0, res_pc=0x00400010 → next cycle out_valid=1, bcres=1, mispredict=1, count=1. pred_taken is 1 from that cycle (counter 10).
- Signed vs unsigned compare, WIDTH=32, a=0xFFFFFFFF, b=1: bf=0100 → bcres=1, bf=0110 → bcres=0, bf=1100 → bcres=1, bf=1110 → bcres=0.
- Saturation: resolve the same PC as taken 5 times back-to-back → counter reaches 11 and stays. Two not-taken resolutions → counter 01, pred_taken=0. out_valid is high on each of the 7 consecutive cycles.
- res_valid=1 with flush=1, bf=1000, a=b → out_valid stays 0, BHT and count unchanged. bf=1111 with res_pred=1 → illegal_bf=1, bcres=0, mispredict=0, BHT unchanged.
- Same-cycle pred/res on one index (counter 01, resolve taken) → pred_taken=0 that cycle and 1 the next. Assert rst_n=0 mid-stream with out_valid=1 → all outputs 0 immediately, BHT back to 01.
- CNT_WIDTH=4, 20 forced mispredicts → mispredict_count stops at 15. Repeat with BHT_ENTRIES=2, WIDTH=8 → indices alias correctly on pc[2].
